// File: rtl/pcie_ocp_pkg.sv
// rtl/pcie_ocp_pkg.sv - shared codes and state encoding for the OCP-to-AXI completion path
package pcie_ocp_pkg;

  // OCP SResp encodings
  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_FAIL = 2'b10;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  // Fmt/Type byte for completions with and without data
  localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;
  localparam logic [7:0] FMT_TYPE_CPL  = 8'h0A;

  // Completion status codes
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_HDR0,
    ST_HDR1,
    ST_COLLECT,
    ST_SEND,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/cpl_hdr_pack.sv
// rtl/cpl_hdr_pack.sv - combinational 3DW completion header former
module cpl_hdr_pack
  import pcie_ocp_pkg::*;
(
  input  logic [9:0]  len_i,
  input  logic [15:0] rid_i,
  input  logic [7:0]  tag_i,
  input  logic [6:0]  la_i,
  input  logic [15:0] cid_i,
  input  logic [2:0]  status_i,
  output logic [31:0] dw0_o,
  output logic [31:0] dw1_o,
  output logic [31:0] dw2_o
);

  logic        cpld;
  logic [11:0] bc;
  logic [9:0]  len_field;

  // Only a successful completion carries data; aborted ones go out as Cpl
  assign cpld      = (status_i == CPL_SC);
  // length*4 truncated to 12 bits, so 1024 DW naturally encodes as 0
  assign bc        = {len_i, 2'b00};
  assign len_field = cpld ? len_i : 10'd0;

  assign dw0_o = {len_field[7:0], 6'd0, len_field[9:8], 8'h00,
                  cpld ? FMT_TYPE_CPLD : FMT_TYPE_CPL};
  assign dw1_o = {bc[7:0], status_i, 1'b0, bc[11:8], cid_i[7:0], cid_i[15:8]};
  assign dw2_o = {1'b0, la_i, tag_i, rid_i[7:0], rid_i[15:8]};

endmodule

// File: rtl/ocp2axi.sv
// rtl/ocp2axi.sv - builds PCIe completion TLPs from OCP read responses onto an AXI stream
module ocp2axi
  import pcie_ocp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_length,
  input  logic [15:0] req_requester_id,
  input  logic [7:0]  req_tag,
  input  logic [6:0]  req_lower_addr,
  input  logic [15:0] completer_id,
  input  logic [1:0]  s_resp,
  input  logic [31:0] s_data,
  output logic        m_respaccept,
  output logic        s_axis_tvalid,
  input  logic        s_axis_tready,
  output logic [63:0] s_axis_tdata,
  output logic [7:0]  s_axis_tkeep,
  output logic        s_axis_tlast,
  output logic        cpl_err
);

  state_e      state_q, state_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [6:0]  la_q, la_d;
  logic [31:0] hold_q, hold_d;
  logic [2:0]  status_q, status_d;
  logic        sticky_q, sticky_d;
  logic [10:0] rem_q, rem_d;
  logic [63:0] pair_q, pair_d;
  logic        half_q, half_d;
  logic        last_q, last_d;
  logic        phase_q, phase_d;
  logic [31:0] dw0, dw1, dw2;
  logic        resp_valid;

  assign resp_valid = (s_resp != SRESP_NULL);

  cpl_hdr_pack u_hdr (
    .len_i    (len_q),
    .rid_i    (rid_q),
    .tag_i    (tag_q),
    .la_i     (la_q),
    .cid_i    (completer_id),
    .status_i (status_q),
    .dw0_o    (dw0),
    .dw1_o    (dw1),
    .dw2_o    (dw2)
  );

  // State and datapath registers; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      rid_q    <= '0;
      tag_q    <= '0;
      la_q     <= '0;
      hold_q   <= '0;
      status_q <= CPL_SC;
      sticky_q <= 1'b0;
      rem_q    <= '0;
      pair_q   <= '0;
      half_q   <= 1'b0;
      last_q   <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rid_q    <= rid_d;
      tag_q    <= tag_d;
      la_q     <= la_d;
      hold_q   <= hold_d;
      status_q <= status_d;
      sticky_q <= sticky_d;
      rem_q    <= rem_d;
      pair_q   <= pair_d;
      half_q   <= half_d;
      last_q   <= last_d;
      phase_q  <= phase_d;
    end
  end

  // Next state, response capture and stream presentation; presented beats come
  // only from registers so they stay frozen while the FIFO stalls
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    rid_d         = rid_q;
    tag_d         = tag_q;
    la_d          = la_q;
    hold_d        = hold_q;
    status_d      = status_q;
    sticky_d      = sticky_q;
    rem_d         = rem_q;
    pair_d        = pair_q;
    half_d        = half_q;
    last_d        = last_q;
    phase_d       = phase_q;
    req_ready     = 1'b0;
    m_respaccept  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          len_d    = req_length;
          rid_d    = req_requester_id;
          tag_d    = req_tag;
          la_d     = req_lower_addr;
          rem_d    = (req_length == 10'd0) ? 11'd1024 : {1'b0, req_length};
          sticky_d = 1'b0;
          status_d = CPL_SC;
          phase_d  = 1'b0;
          state_d  = ST_FIRST;
        end
      end
      ST_FIRST: begin
        m_respaccept = 1'b1;
        if (resp_valid) begin
          hold_d   = s_data;
          status_d = (s_resp == SRESP_DVA) ? CPL_SC : CPL_CA;
          rem_d    = rem_q - 11'd1;
          state_d  = ST_HDR0;
        end
      end
      ST_HDR0: begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {dw1, dw0};
        s_axis_tkeep  = 8'hFF;
        if (s_axis_tready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        s_axis_tvalid = 1'b1;
        if (status_q == CPL_SC) begin
          s_axis_tdata = {hold_q, dw2};
          s_axis_tkeep = 8'hFF;
          s_axis_tlast = (rem_q == 11'd0);
          if (s_axis_tready) state_d = (rem_q == 11'd0) ? ST_IDLE : ST_COLLECT;
        end else begin
          s_axis_tdata = {32'd0, dw2};
          s_axis_tkeep = 8'h0F;
          s_axis_tlast = 1'b1;
          if (s_axis_tready) state_d = (rem_q == 11'd0) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_COLLECT: begin
        m_respaccept = 1'b1;
        if (resp_valid) begin
          rem_d = rem_q - 11'd1;
          if (s_resp != SRESP_DVA) sticky_d = 1'b1;
          if (!phase_q) begin
            pair_d = {32'd0, s_data};
            if (rem_q == 11'd1) begin
              half_d  = 1'b1;
              last_d  = 1'b1;
              state_d = ST_SEND;
            end else begin
              phase_d = 1'b1;
            end
          end else begin
            pair_d  = {s_data, pair_q[31:0]};
            half_d  = 1'b0;
            last_d  = (rem_q == 11'd1);
            phase_d = 1'b0;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pair_q;
        s_axis_tkeep  = half_q ? 8'h0F : 8'hFF;
        s_axis_tlast  = last_q;
        if (s_axis_tready) state_d = last_q ? ST_IDLE : ST_COLLECT;
      end
      ST_DRAIN: begin
        m_respaccept = 1'b1;
        if (resp_valid) begin
          rem_d = rem_q - 11'd1;
          if (rem_q == 11'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Errored-completion pulse rides on the transfer of the final beat
  assign cpl_err = s_axis_tvalid & s_axis_tready & s_axis_tlast &
                   (sticky_q | (status_q == CPL_CA));

endmodule

// File: tb/tb_ocp2axi.sv
// tb/tb_ocp2axi.sv - randomized self-checking bench for ocp2axi against a TLP-level model
module tb_ocp2axi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_length = '0;
  logic [15:0] req_requester_id = '0;
  logic [7:0]  req_tag = '0;
  logic [6:0]  req_lower_addr = '0;
  logic [15:0] completer_id = '0;
  logic [1:0]  s_resp = '0;
  logic [31:0] s_data = '0;
  logic        m_respaccept;
  logic        s_axis_tvalid;
  logic        s_axis_tready = 1'b1;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        cpl_err;

  always #5 clk = ~clk;

  ocp2axi dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_length       (req_length),
    .req_requester_id (req_requester_id),
    .req_tag          (req_tag),
    .req_lower_addr   (req_lower_addr),
    .completer_id     (completer_id),
    .s_resp           (s_resp),
    .s_data           (s_data),
    .m_respaccept     (m_respaccept),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .cpl_err          (cpl_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  rc [1024];
  logic [31:0] rd [1024];
  logic [63:0] got_d[$], exp_d[$];
  logic [7:0]  got_k[$], exp_k[$];
  logic        got_l[$], exp_l[$];
  logic        exp_err;
  int err_pulses, unstable, overlap, timed_out, first_acc, first_tv, consumed;

  // Response stream for the next packet: all DVA with random data, optional overrides
  task automatic fill(input logic [1:0] first_code, input int err_idx);
    for (int i = 0; i < 1024; i++) begin
      rc[i] = 2'b01;
      rd[i] = $urandom;
    end
    rc[0] = first_code;
    if (err_idx > 0) rc[err_idx] = 2'b10;
  endtask

  // Reference: list header DWs then payload DWs, cut into little-endian DW pairs
  task automatic build_exp(input logic [9:0] len, input logic [15:0] rid,
                           input logic [7:0] tag, input logic [6:0] la);
    int          n;
    logic        ca;
    logic [11:0] bc;
    logic [9:0]  lf;
    logic [31:0] dws[$];
    n  = (len == 10'd0) ? 1024 : int'(len);
    ca = (rc[0] != 2'b01);
    bc = 12'((n * 4) % 4096);
    lf = ca ? 10'd0 : 10'(n % 1024);
    dws.delete();
    dws.push_back({lf[7:0], 6'd0, lf[9:8], 8'd0, ca ? 8'h0A : 8'h4A});
    dws.push_back({bc[7:0], ca ? 3'b100 : 3'b000, 1'b0, bc[11:8],
                   completer_id[7:0], completer_id[15:8]});
    dws.push_back({1'b0, la, tag, rid[7:0], rid[15:8]});
    exp_err = ca;
    if (!ca) begin
      for (int i = 0; i < n; i++) dws.push_back(rd[i]);
      for (int i = 1; i < n; i++) if (rc[i] != 2'b01) exp_err = 1'b1;
    end
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    for (int i = 0; i < dws.size(); i += 2) begin
      if (i + 1 < dws.size()) begin
        exp_d.push_back({dws[i+1], dws[i]});
        exp_k.push_back(8'hFF);
      end else begin
        exp_d.push_back({32'd0, dws[i]});
        exp_k.push_back(8'h0F);
      end
      exp_l.push_back(i + 2 >= dws.size());
    end
  endtask

  // Issue one descriptor, act as OCP slave and FIFO sink; tmode 0 ready, 1 toggle, 2 random
  task automatic run_tlp(input logic [9:0] len, input logic [15:0] rid, input logic [7:0] tag,
                         input logic [6:0] la, input int tmode, input int gaps, input int abort_at);
    int          n, cyc, budget;
    logic        acc, cons, done, pstall, seen_last;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    n = (len == 10'd0) ? 1024 : int'(len);
    got_d.delete(); got_k.delete(); got_l.delete();
    err_pulses = 0; unstable = 0; overlap = 0; timed_out = 0;
    first_acc = -1; first_tv = -1; consumed = 0;
    cyc = 0; budget = 20 * n + 200;
    done = 0; pstall = 0; seen_last = 0; pd = '0; pk = '0; pl = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_length = len; req_requester_id = rid;
    req_tag = tag; req_lower_addr = la;
    s_resp = 2'b00;
    while (!done) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      if (s_axis_tvalid && first_tv < 0) first_tv = cyc;
      if (m_respaccept && s_axis_tvalid) overlap++;
      if (pstall && (!s_axis_tvalid || s_axis_tdata !== pd || s_axis_tkeep !== pk ||
                     s_axis_tlast !== pl)) unstable++;
      pstall = s_axis_tvalid && !s_axis_tready;
      pd = s_axis_tdata; pk = s_axis_tkeep; pl = s_axis_tlast;
      if (cpl_err) err_pulses++;
      if (s_axis_tvalid && s_axis_tready) begin
        got_d.push_back(s_axis_tdata);
        got_k.push_back(s_axis_tkeep);
        got_l.push_back(s_axis_tlast);
        if (s_axis_tlast) seen_last = 1;
      end
      cons = m_respaccept && (s_resp != 2'b00);
      if (cons) begin
        if (first_acc < 0) first_acc = cyc;
        consumed++;
      end
      cyc++;
      if (abort_at > 0 && got_d.size() >= abort_at) done = 1;
      else if (seen_last && consumed >= n) done = 1;
      else if (cyc > budget) begin timed_out = 1; done = 1; end
      @(posedge clk); #1;
      if (acc) req_valid = 1'b0;
      if (!(s_resp != 2'b00 && !cons)) begin
        if (consumed < n && (gaps == 0 || $urandom_range(0, 2) != 0)) begin
          s_resp = rc[consumed];
          s_data = rd[consumed];
        end else begin
          s_resp = 2'b00;
          s_data = $urandom;
        end
      end
      case (tmode)
        0:       s_axis_tready = 1'b1;
        1:       s_axis_tready = cyc[0];
        default: s_axis_tready = ($urandom_range(0, 1) == 1);
      endcase
    end
    req_valid = 1'b0;
    if (abort_at == 0) s_resp = 2'b00;
    s_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    n_tests++; if (s_axis_tvalid !== 1'b0 || s_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid_tlast got %b%b want 00", s_axis_tvalid, s_axis_tlast); end
    n_tests++; if (s_axis_tdata !== 64'd0 || s_axis_tkeep !== 8'd0) begin n_fail++; $display("FAIL reset_tdata_tkeep got %h/%h want 0/0", s_axis_tdata, s_axis_tkeep); end
    n_tests++; if (m_respaccept !== 1'b0 || cpl_err !== 1'b0) begin n_fail++; $display("FAIL reset_accept_err got %b%b want 00", m_respaccept, cpl_err); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_single_dw();
    completer_id = 16'h0200;
    fill(2'b01, 0);
    rd[0] = 32'hDEADBEEF;
    run_tlp(10'd1, 16'h0100, 8'h05, 7'h04, 0, 0, 0);
    n_tests++; if (got_d.size() != 2) begin n_fail++; $display("FAIL single_beats got %0d want 2", got_d.size()); end
    n_tests++; if (got_d[0] !== 64'h04000002_0100004A || got_k[0] !== 8'hFF || got_l[0] !== 1'b0) begin n_fail++; $display("FAIL single_beat0 got %h/%h/%b want 040000020100004a/ff/0", got_d[0], got_k[0], got_l[0]); end
    n_tests++; if (got_d[1] !== 64'hDEADBEEF_04050001 || got_k[1] !== 8'hFF || got_l[1] !== 1'b1) begin n_fail++; $display("FAIL single_beat1 got %h/%h/%b want deadbeef04050001/ff/1", got_d[1], got_k[1], got_l[1]); end
    n_tests++; if (first_tv - first_acc != 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", first_tv - first_acc); end
    n_tests++; if (err_pulses != 0 || timed_out != 0) begin n_fail++; $display("FAIL single_err_timeout got %0d/%0d want 0/0", err_pulses, timed_out); end
  endtask

  task automatic test_lengths();
    int lens[3] = '{3, 4, 2};
    foreach (lens[j]) begin
      completer_id = 16'($urandom);
      fill(2'b01, 0);
      build_exp(10'(lens[j]), 16'h1234, 8'(j), 7'h10);
      run_tlp(10'(lens[j]), 16'h1234, 8'(j), 7'h10, 0, 1, 0);
      n_tests++; if (got_d.size() != exp_d.size() || timed_out != 0) begin n_fail++; $display("FAIL len%0d_beats got %0d want %0d", lens[j], got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        n_tests++;
        if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
          n_fail++; $display("FAIL len%0d_beat%0d got %h/%h/%b want %h/%h/%b", lens[j], i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    completer_id = 16'hA5C3;
    fill(2'b01, 0);
    build_exp(10'd8, 16'hBEEF, 8'h77, 7'h3C);
    run_tlp(10'd8, 16'hBEEF, 8'h77, 7'h3C, 1, 1, 0);
    n_tests++; if (got_d.size() != exp_d.size() || timed_out != 0) begin n_fail++; $display("FAIL bp_beats got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL bp_beat%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
    n_tests++; if (overlap != 0) begin n_fail++; $display("FAIL bp_accept_while_sending got %0d want 0", overlap); end
  endtask

  task automatic test_error_first();
    completer_id = 16'h0200;
    fill(2'b11, 0);
    build_exp(10'd4, 16'h0100, 8'h09, 7'h08);
    run_tlp(10'd4, 16'h0100, 8'h09, 7'h08, 0, 1, 0);
    n_tests++; if (got_d.size() != 2 || timed_out != 0) begin n_fail++; $display("FAIL errfirst_beats got %0d want 2", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL errfirst_beat%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    n_tests++; if (got_d[0][7:0] !== 8'h0A || got_d[0][55:53] !== 3'b100 || got_d[0][63:56] !== 8'd16) begin n_fail++; $display("FAIL errfirst_fields got fmt %h st %b bc %0d want 0a 100 16", got_d[0][7:0], got_d[0][55:53], got_d[0][63:56]); end
    n_tests++; if (got_k[1] !== 8'h0F) begin n_fail++; $display("FAIL errfirst_keep got %h want 0f", got_k[1]); end
    n_tests++; if (consumed != 4 || err_pulses != 1) begin n_fail++; $display("FAIL errfirst_drain_err got %0d/%0d want 4/1", consumed, err_pulses); end
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL errfirst_idle got %b want 1", req_ready); end
  endtask

  task automatic test_late_error();
    completer_id = 16'h0F0F;
    fill(2'b01, 2);
    build_exp(10'd5, 16'h0042, 8'h21, 7'h7F);
    run_tlp(10'd5, 16'h0042, 8'h21, 7'h7F, 2, 1, 0);
    n_tests++; if (got_d.size() != exp_d.size() || timed_out != 0) begin n_fail++; $display("FAIL lateerr_beats got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL lateerr_beat%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    n_tests++; if (err_pulses != 1) begin n_fail++; $display("FAIL lateerr_pulse got %0d want 1", err_pulses); end
  endtask

  task automatic test_len0();
    int lasts;
    completer_id = 16'h3344;
    fill(2'b01, 0);
    build_exp(10'd0, 16'h5566, 8'h80, 7'h00);
    run_tlp(10'd0, 16'h5566, 8'h80, 7'h00, 2, 0, 0);
    n_tests++; if (got_d.size() != exp_d.size() || timed_out != 0) begin n_fail++; $display("FAIL len0_beats got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL len0_beat%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    n_tests++; if (got_d[0][17:16] !== 2'b00 || got_d[0][31:24] !== 8'h00 || got_d[0][51:48] !== 4'h0 || got_d[0][63:56] !== 8'h00) begin n_fail++; $display("FAIL len0_fields got %h want len 0 bc 0", got_d[0]); end
    lasts = 0;
    foreach (got_l[i]) if (got_l[i]) lasts++;
    n_tests++; if (lasts != 1 || got_l[got_l.size()-1] !== 1'b1) begin n_fail++; $display("FAIL len0_tlast got %0d lasts want 1 on final beat", lasts); end
  endtask

  task automatic test_reset_in_send();
    int   seen;
    logic any_last;
    completer_id = 16'h1234;
    fill(2'b01, 0);
    run_tlp(10'd8, 16'h0001, 8'h01, 7'h00, 0, 0, 3);
    s_axis_tready = 1'b0;
    s_resp = 2'b01;
    s_data = $urandom;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (s_axis_tvalid) seen = 1;
    end
    n_tests++; if (seen != 1) begin n_fail++; $display("FAIL rst_reach_send got %0d want 1", seen); end
    any_last = 1'b0;
    foreach (got_l[i]) if (got_l[i]) any_last = 1'b1;
    n_tests++; if (any_last !== 1'b0) begin n_fail++; $display("FAIL rst_no_tlast got %b want 0", any_last); end
    @(posedge clk); #1;
    reset = 1'b1; s_resp = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++; if (s_axis_tvalid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_after%0d got tvalid %b ready %b want 0 1", i, s_axis_tvalid, req_ready); end
    end
    s_axis_tready = 1'b1;
    fill(2'b01, 0);
    build_exp(10'd2, 16'h0002, 8'h02, 7'h01);
    run_tlp(10'd2, 16'h0002, 8'h02, 7'h01, 0, 1, 0);
    n_tests++; if (got_d.size() != exp_d.size() || timed_out != 0) begin n_fail++; $display("FAIL rst_next_beats got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
        n_fail++; $display("FAIL rst_next_beat%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [6:0]  la;
    logic [1:0]  first;
    for (int k = 0; k < 8; k++) begin
      len   = 10'($urandom_range(1, 40));
      rid   = 16'($urandom);
      tag   = 8'($urandom);
      la    = 7'($urandom);
      first = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'b01;
      completer_id = 16'($urandom);
      fill(first, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 39)) : 0);
      build_exp(len, rid, tag, la);
      run_tlp(len, rid, tag, la, 2, 1, 0);
      n_tests++; if (got_d.size() != exp_d.size() || timed_out != 0) begin n_fail++; $display("FAIL rnd%0d_beats got %0d want %0d", k, got_d.size(), exp_d.size()); end
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
        n_tests++;
        if (got_d[i] !== exp_d[i] || got_k[i] !== exp_k[i] || got_l[i] !== exp_l[i]) begin
          n_fail++; $display("FAIL rnd%0d_beat%0d got %h/%h/%b want %h/%h/%b", k, i, got_d[i], got_k[i], got_l[i], exp_d[i], exp_k[i], exp_l[i]);
        end
      end
      n_tests++; if (err_pulses != int'(exp_err) || unstable != 0) begin n_fail++; $display("FAIL rnd%0d_err_stable got %0d/%0d want %0d/0", k, err_pulses, unstable, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_dw();
    test_lengths();
    test_backpressure();
    test_error_first();
    test_late_error();
    test_len0();
    test_reset_in_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
